// File: rtl/dm_banked_ctrl.sv
// Byte-addressed data memory with req/ready handshake, 1-cycle registered loads and a post-reset clear sweep.
// Optional per-byte even parity with error injection is enabled by defining DM_PARITY_EN.
module dm_banked_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [31:0]           din,
  output logic                  ready,
  output logic                  rvalid,
  output logic [31:0]           dout,
  output logic                  misalign
`ifdef DM_PARITY_EN
  ,
  input  logic                  inj_par,
  output logic                  parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef DM_PARITY_EN
  localparam int MW = 36;
`else
  localparam int MW = 32;
`endif

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic [MW-1:0]           mem [DEPTH];

  logic                    acc;
  logic                    mis;
  logic [ADDR_WIDTH-1:0]   widx;
  logic [1:0]              lane;
  logic [MW-1:0]           rd_word;
  logic [MW-1:0]           wr_word;

  logic                    vld_p1;
  logic                    mis_p1;
  logic [31:0]             dout_p1;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] ln);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return ln[0];
      2'b10:   return |ln;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] ln, input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001 << ln;
      2'b01:   return ln[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Stores arrive right-aligned; replicate so every lane sees its own slice.
  function automatic logic [31:0] merge_data(input logic [31:0] old, input logic [31:0] d,
                                             input logic [1:0] ln, input logic [1:0] sz);
    logic [31:0] src;
    logic [3:0]  be;
    logic [31:0] w;
    w  = old;
    be = lane_en(ln, sz);
    case (sz)
      2'b00:   src = {4{d[7:0]}};
      2'b01:   src = {2{d[15:0]}};
      default: src = d;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w[8*i +: 8] = src[8*i +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] ln,
                                           input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*ln +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return {{24{sx & b[7]}}, b};
      2'b01:   return {{16{sx & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Control: clear sweep followed by the idle/accept state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_CLEAR ? S_INIT : S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == S_INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (&cnt) state_nxt = S_IDLE;
    end
  end

  assign ready = (state == S_IDLE) && rst_n;
  assign acc   = req && ready;
  assign widx  = addr[ADDR_WIDTH+1:2];
  assign lane  = addr[1:0];
  assign mis   = is_misaligned(size, lane);
  assign rd_word = mem[widx];

`ifdef DM_PARITY_EN
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        perr_rd;
  logic        perr_p1;

  always_comb begin
    wr_be   = lane_en(lane, size);
    wr_data = merge_data(rd_word[31:0], din, lane, size);
    wr_word = {rd_word[35:32], wr_data};
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) wr_word[32+i] = (^wr_data[8*i +: 8]) ^ inj_par;
    end
  end

  // Even parity: each stored byte plus its parity bit must hold an even number of ones.
  always_comb begin
    perr_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      perr_rd = perr_rd | (^{rd_word[32+i], rd_word[8*i +: 8]});
    end
  end
`else
  assign wr_word = merge_data(rd_word, din, lane, size);
`endif

  // Array: sweep writes zero (parity of zero is zero), otherwise aligned stores
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= '0;
    end else if (acc && we && !mis) begin
      mem[widx] <= wr_word;
    end
  end

  // Stage p1: load result and status registered one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      mis_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      vld_p1 <= acc && !we;
      mis_p1 <= acc && mis;
      if (acc && !we) begin
        dout_p1 <= mis ? 32'h0 : load_ext(rd_word[31:0], lane, size, sign_ext);
      end
    end
  end

`ifdef DM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_p1 <= 1'b0;
    else        perr_p1 <= acc && !we && !mis && perr_rd;
  end
  assign parity_err = perr_p1;
`endif

  assign rvalid   = vld_p1;
  assign misalign = mis_p1;
  assign dout     = dout_p1;

endmodule

// File: tb/tb_dm_banked_ctrl.sv
// Scoreboard bench for dm_banked_ctrl: byte-array reference model, directed and random traffic.
// Define DM_PARITY_EN to also exercise parity storage and injection.
module tb_dm_banked_ctrl;

  localparam int AW = 10;
  localparam int NBYTES = 4 * (2 ** AW);

  logic          clk, rst_n, req, we, sign_ext;
  logic [AW+1:0] addr;
  logic [1:0]    size;
  logic [31:0]   din;
  logic          ready, rvalid, misalign;
  logic [31:0]   dout;
`ifdef DM_PARITY_EN
  logic          inj_par, parity_err;
`endif

  dm_banked_ctrl #(.ADDR_WIDTH(AW), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .size(size),
    .sign_ext(sign_ext), .din(din), .ready(ready), .rvalid(rvalid), .dout(dout),
    .misalign(misalign)
`ifdef DM_PARITY_EN
    , .inj_par(inj_par), .parity_err(parity_err)
`endif
  );

  typedef struct {
    int          due;
    bit          rv;
    bit          mis;
    logic [31:0] d;
    bit          pe;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          neg_cnt = 0;
  logic [31:0] last_dout = 32'h0;
  logic [7:0]  ref_mem [NBYTES];
  bit          ref_bad [NBYTES];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) begin
      ref_mem[i] = 8'h00;
      ref_bad[i] = 1'b0;
    end
  endtask

  // Reference: memory is a flat little-endian byte array; a size-s access covers 2**s bytes.
  task automatic model_access(input bit w, input logic [AW+1:0] a, input logic [1:0] sz,
                              input bit sx, input logic [31:0] d, input bit inj);
    exp_t        e;
    int          base, n;
    logic [31:0] v;
    bit          bad;
    e.due = neg_cnt + 1;
    e.rv  = !w;
    e.d   = 32'h0;
    e.pe  = 1'b0;
    e.mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    base  = int'(a);
    n     = 1 << sz;
    if (!e.mis) begin
      if (w) begin
        for (int i = 0; i < n; i++) begin
          ref_mem[base+i] = d[8*i +: 8];
          ref_bad[base+i] = inj;
        end
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
        if (sx && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (sx && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) bad = bad | ref_bad[(base & ~3) + i];
        e.d  = v;
        e.pe = bad;
      end
    end
    if (e.rv || e.mis) q.push_back(e);
  endtask

  // Called at #1 after a rising edge; leaves the bench at #1 after the accepting edge.
  task automatic do_req(input bit w, input logic [AW+1:0] a, input logic [1:0] sz,
                        input bit sx, input logic [31:0] d, input bit inj);
    req = 1'b1; we = w; addr = a; size = sz; sign_ext = sx; din = d;
`ifdef DM_PARITY_EN
    inj_par = inj;
`endif
    chk("ready_at_issue", {31'h0, ready}, 32'h1);
    @(posedge clk);
    model_access(w, a, sz, sx, d, inj);
    #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string nm, input int want);
    int n;
    n = 0;
    while (!ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, n, want);
    if (ready) model_clear();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready",    {31'h0, ready},    32'h0);
    chk("rst_rvalid",   {31'h0, rvalid},   32'h0);
    chk("rst_dout",     dout,              32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
  endtask

  // Monitor: every falling edge either retires the expected response or checks quiet outputs.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (!rst_n) begin
      last_dout = 32'h0;
    end else if (q.size() > 0 && q[0].due == neg_cnt) begin
      e = q.pop_front();
      if (e.rv) last_dout = e.d;
      n_tests++;
      if (rvalid !== e.rv || misalign !== e.mis || dout !== last_dout
`ifdef DM_PARITY_EN
          || parity_err !== (e.rv & e.pe)
`endif
         ) begin
        n_fail++;
        $display("FAIL resp@%0d: got rv=%b mis=%b dout=%h want rv=%b mis=%b dout=%h pe=%b",
                 neg_cnt, rvalid, misalign, dout, e.rv, e.mis, last_dout, e.pe);
      end
    end else begin
      n_tests++;
      if (rvalid !== 1'b0 || misalign !== 1'b0 || dout !== last_dout) begin
        n_fail++;
        $display("FAIL quiet@%0d: got rv=%b mis=%b dout=%h want rv=0 mis=0 dout=%h",
                 neg_cnt, rvalid, misalign, dout, last_dout);
      end
    end
  end

  initial begin
    logic [1:0]    rsz;
    logic [AW+1:0] ra;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; size = 2'd0; sign_ext = 1'b0; din = 32'h0;
`ifdef DM_PARITY_EN
    inj_par = 1'b0;
`endif
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    wait_ready("init_ready_cycles", 1024);

    do_req(0, 12'h004, 2'd2, 0, 32'h0, 0);

    do_req(1, 12'h010, 2'd2, 0, 32'h80FF7F01, 0);
    for (int i = 0; i < 4; i++) begin
      do_req(0, 12'h010 + 12'(i), 2'd0, 1, 32'h0, 0);
      do_req(0, 12'h010 + 12'(i), 2'd0, 0, 32'h0, 0);
    end
    do_req(0, 12'h012, 2'd1, 1, 32'h0, 0);
    do_req(0, 12'h010, 2'd1, 0, 32'h0, 0);

    do_req(1, 12'h020, 2'd2, 0, 32'h11223344, 0);
    idle(1);
    do_req(1, 12'h022, 2'd1, 0, 32'h0000BEEF, 0);
    do_req(0, 12'h020, 2'd2, 0, 32'h0, 0);

    do_req(0, 12'h006, 2'd2, 0, 32'h0, 0);
    do_req(1, 12'h030, 2'd2, 0, 32'hA5A55A5A, 0);
    do_req(1, 12'h031, 2'd1, 0, 32'h00001234, 0);
    do_req(0, 12'h030, 2'd2, 0, 32'h0, 0);
    do_req(0, 12'h030, 2'd3, 1, 32'h0, 0);
    do_req(1, 12'h034, 2'd3, 0, 32'hFFFFFFFF, 0);
    do_req(0, 12'h033, 2'd1, 1, 32'h0, 0);
    do_req(0, 12'hFFC, 2'd2, 0, 32'h0, 0);

    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      rsz = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? (AW+2)'($urandom) : (AW+2)'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), ra, rsz, 1'($urandom_range(0, 1)), $urandom,
             ($urandom_range(0, 5) == 0));
    end

    idle(2);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs();
    rst_n = 1'b1;
    idle(300);
    chk("mid_init_ready", {31'h0, ready}, 32'h0);
    req = 1'b1; we = 1'b0; addr = 12'h100; size = 2'd2; sign_ext = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wait_ready("reinit_ready_cycles", 1024);
    req = 1'b0;
    idle(1);
    do_req(0, 12'h010, 2'd2, 0, 32'h0, 0);
    do_req(0, 12'h034, 2'd2, 0, 32'h0, 0);

`ifdef DM_PARITY_EN
    do_req(1, 12'h040, 2'd2, 0, 32'h12345678, 1);
    do_req(0, 12'h041, 2'd0, 0, 32'h0, 0);
    do_req(1, 12'h040, 2'd2, 0, 32'h12345678, 0);
    do_req(0, 12'h041, 2'd0, 0, 32'h0, 0);
    do_req(1, 12'h043, 2'd0, 0, 32'h000000AB, 1);
    do_req(0, 12'h040, 2'd0, 0, 32'h0, 0);
`endif

    idle(3);
    chk("scoreboard_drained", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_banked_ctrl.md
Name: dm_banked_ctrl

Overview:
- Parametrised successor to the 4 KB word data memory used by the single-cycle/multi-cycle CPU datapath.
- Adds byte-addressed sub-word access (byte/half/word) with byte-lane writes and sign/zero-extended loads.
- Adds a req/ready handshake with a registered, one-cycle read latency.
- Adds a post-reset hardware clear sweep, so software always sees zeroed memory.

Parameters:
- ADDR_WIDTH, 10, word-address bits; DEPTH = 2**ADDR_WIDTH words (default 4 KB).
- INIT_CLEAR, 1, 1 = zero the array after reset before accepting requests; 0 = no sweep, memory contents undefined.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request strobe.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  ADDR_WIDTH+2  byte address.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- din  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  output  1  block can accept a request this cycle.
- rvalid  output  1  one-cycle pulse; dout is valid.
- dout  output  32  load result, extended to 32 bits.
- misalign  output  1  one-cycle pulse flagging a rejected request.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: ready=0, rvalid=0, dout=0, misalign=0.
  - State: clear counter=0; state=INIT if INIT_CLEAR=1, else IDLE.
  - Array contents are not reset.
- FSM states: INIT, IDLE.
  - INIT: each cycle writes 0 to mem[cnt], then cnt++. After writing word DEPTH-1, the next state is IDLE.
  - ready=1 only in IDLE, so ready rises exactly DEPTH cycles after rst_n deasserts.
  - req is ignored during INIT.
  - Reset asserted mid-INIT restarts the sweep from word 0.
- Acceptance: a request is accepted when req=1 and ready=1 at a rising edge. A new request may be accepted every cycle.
- Byte lanes are little-endian: lane = addr[1:0]; word index = addr[ADDR_WIDTH+1:2].
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - size=11 is always misaligned.
- Misaligned request:
  - No array change.
  - misalign=1 in the cycle after acceptance.
  - For a load, rvalid=1 with dout=0 in that same cycle.
- Store: the selected lanes are written at the accepting edge; other lanes are untouched. Half writes lanes {addr[1],0} and {addr[1],1}. No rvalid is produced.
- Load:
  - The word is read at the accepting edge.
  - rvalid=1 and dout=extended lane data in the following cycle (latency 1).
  - Half data = {lane hi, lane lo}.
  - Sign extension replicates bit 7 (byte) or bit 15 (half). Word loads ignore sign_ext.
- dout holds its last value while rvalid=0.
- A load accepted the cycle after a store to the same word returns the new data.
- Addresses wrap naturally within ADDR_WIDTH+2 bits; no out-of-range condition exists.

Optional Feature:
- Macro: DM_PARITY_EN.
- When defined:
  - One even-parity bit per byte is stored, giving a 36-bit array.
  - Extra input inj_par (1 bit) inverts the parity bits of the lanes written by a store.
  - Extra output parity_err (1 bit, reset 0) pulses together with rvalid if any byte of the read word, selected lanes or not, fails its parity check.
  - The INIT sweep writes correct parity.
- When undefined: no parity storage, no inj_par or parity_err ports, behaviour otherwise identical.

Test Plan:
1. Release rst_n, INIT_CLEAR=1, ADDR_WIDTH=10 -> ready stays 0 for 1024 cycles, then 1. Load word at 0x004 -> rvalid one cycle later, dout=0x00000000.
2. Store word 0x80FF7F01 at 0x010. Then load bytes at 0x010–0x013, alternating sign_ext=1 and 0:
   - sign_ext=1 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
   - sign_ext=0 -> 0x01, 0x7F, 0xFF, 0x80.
3. Store half 0xBEEF at 0x022 over word 0x11223344, then load word 0x020 -> 0xBEEF3344. Store issued back-to-back with the load -> new value returned.
4. Word load at 0x006 -> misalign=1, rvalid=1, dout=0. Half store at 0x031 -> misalign=1 and the word is unchanged. size=11 -> misalign=1.
5. Assert rst_n=0 at cycle 300 of INIT, release -> ready rises 1024 cycles after release. A request held during INIT is not accepted.
6. (DM_PARITY_EN) Store word at 0x040 with inj_par=1, then load byte 0x041 -> parity_err=1 with rvalid. Rewrite with inj_par=0 -> parity_err=0.
